// File: rtl/plot_pkg.sv
// Shared constants and state encoding for the plot difference-stream path.
package plot_pkg;

    localparam int VW       = 10;
    localparam int DW       = 7;
    localparam int KEY_FLAG = 7;
    localparam logic [VW-1:0] VMAX = 10'd1023;

    typedef enum logic [1:0] {
        NOSYNC,
        KEY_LO,
        RUN
    } state_t;

endpackage

// File: rtl/plot_sat_add.sv
// Saturating add of a signed delta to an unsigned sample, clamped to [0, 2^VW-1].
module plot_sat_add #(
    parameter int VW = plot_pkg::VW,
    parameter int DW = plot_pkg::DW
) (
    input  logic [VW-1:0] acc,
    input  logic [DW-1:0] delta,
    output logic [VW-1:0] sum,
    output logic          clamp
);

    localparam int WW = VW + 2;

    logic signed [WW-1:0] wide;

    always_comb begin
        wide  = $signed({2'b00, acc}) + $signed({{(WW-DW){delta[DW-1]}}, delta});
        sum   = wide[VW-1:0];
        clamp = 1'b0;
        if (wide < 0) begin
            sum   = '0;
            clamp = 1'b1;
        end else if (wide > $signed({2'b00, {VW{1'b1}}})) begin
            sum   = '1;
            clamp = 1'b1;
        end
    end

endmodule

// File: rtl/plot_delta_decoder.sv
// Rebuilds plot samples from a keyframe/delta byte stream; one byte per cycle,
// output held until the consumer accepts it.
module plot_delta_decoder #(
    parameter int VW = plot_pkg::VW,
    parameter int DW = plot_pkg::DW
) (
    input  logic          m_clock,
    input  logic          p_reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [VW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err,
    output logic          sat,
    output logic          synced
);

    import plot_pkg::*;

    state_t             state;
    logic [VW-1:0]      acc;
    logic [VW-DW-1:0]   hi;
    logic [VW-1:0]      sum;
    logic               clamp;
    logic               take;

    plot_sat_add #(.VW(VW), .DW(DW)) u_add (
        .acc   (acc),
        .delta (in_data[DW-1:0]),
        .sum   (sum),
        .clamp (clamp)
    );

    assign in_ready = ~out_valid | out_ready;
    assign take     = in_valid & in_ready;

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state     <= NOSYNC;
            acc       <= '0;
            hi        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            sat       <= 1'b0;
            synced    <= 1'b0;
        end else begin
            err <= 1'b0;
            sat <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            // An emit below overrides the clear above, so transfer+emit keeps out_valid high.
            if (take) begin
                if (in_data[KEY_FLAG]) begin
                    hi    <= in_data[VW-DW-1:0];
                    state <= KEY_LO;
                    if (state == KEY_LO)
                        err <= 1'b1;
                end else begin
                    case (state)
                        KEY_LO: begin
                            acc       <= {hi, in_data[DW-1:0]};
                            out_data  <= {hi, in_data[DW-1:0]};
                            out_valid <= 1'b1;
                            synced    <= 1'b1;
                            state     <= RUN;
                        end
                        RUN: begin
                            acc       <= sum;
                            out_data  <= sum;
                            out_valid <= 1'b1;
                            sat       <= clamp;
                        end
                        default: err <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_plot_delta_decoder.sv
// Self-checking bench for plot_delta_decoder: directed scenarios plus a randomized run against a reference model.
module tb_plot_delta_decoder;

    logic       m_clock = 1'b0;
    logic       p_reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic       sat;
    logic       synced;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: the pending key-high value, whether a key-low is awaited,
    // whether deltas are meaningful, and the current sample value.
    int m_hi;
    bit m_want_lo;
    bit m_have_sample;
    bit m_sync;
    int m_acc;
    bit m_emit;
    bit m_err;
    bit m_sat;

    plot_delta_decoder #(.VW(10), .DW(7)) dut (
        .m_clock   (m_clock),
        .p_reset   (p_reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .sat       (sat),
        .synced    (synced)
    );

    always #5 m_clock = ~m_clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [13:0] obs();
        return {out_valid, out_data, err, sat, synced};
    endfunction

    function automatic logic [13:0] ev(bit v, int d, bit e, bit s, bit sy);
        logic [9:0] dd;
        dd = d[9:0];
        return {v, dd, e, s, sy};
    endfunction

    function automatic void model_reset();
        m_hi = 0; m_want_lo = 0; m_have_sample = 0; m_sync = 0; m_acc = 0;
        m_emit = 0; m_err = 0; m_sat = 0;
    endfunction

    function automatic void model_step(logic [7:0] b);
        int v;
        int s;
        m_emit = 0; m_err = 0; m_sat = 0;
        v = int'(b[6:0]);
        if (b[7]) begin
            if (m_want_lo) m_err = 1;
            m_hi = int'(b[2:0]);
            m_want_lo = 1;
            m_have_sample = 0;
        end else if (m_want_lo) begin
            m_acc = m_hi * 128 + v;
            m_want_lo = 0;
            m_have_sample = 1;
            m_sync = 1;
            m_emit = 1;
        end else if (m_have_sample) begin
            s = m_acc + ((v >= 64) ? v - 128 : v);
            if (s < 0)    begin s = 0;    m_sat = 1; end
            if (s > 1023) begin s = 1023; m_sat = 1; end
            m_acc = s;
            m_emit = 1;
        end else begin
            m_err = 1;
        end
    endfunction

    task automatic apply_reset();
        p_reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge m_clock);
        @(negedge m_clock);
        p_reset = 1'b0;
        model_reset();
    endtask

    task automatic put_byte(input logic [7:0] b);
        @(negedge m_clock);
        in_data = b;
        in_valid = 1'b1;
        @(posedge m_clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required %h", obs(), 14'd0);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_keyframe();
        logic [7:0]  b [4] = '{8'h83, 8'h05, 8'h02, 8'h7F};
        logic [13:0] e [4];
        e = '{ev(0, 0, 0, 0, 0), ev(1, 389, 0, 0, 1), ev(1, 391, 0, 0, 1), ev(1, 390, 0, 0, 1)};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            put_byte(b[i]);
            n_cmp++;
            if (obs() !== e[i]) begin
                n_bad++;
                $display("FAIL keyframe[%0d]: got %h, required %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_upper_clamp();
        logic [7:0]  b [3] = '{8'h87, 8'h7F, 8'h01};
        logic [13:0] e [3];
        e = '{ev(0, 0, 0, 0, 0), ev(1, 1023, 0, 0, 1), ev(1, 1023, 0, 1, 1)};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            put_byte(b[i]);
            n_cmp++;
            if (obs() !== e[i]) begin
                n_bad++;
                $display("FAIL upper_clamp[%0d]: got %h, required %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_lower_clamp();
        logic [7:0]  b [3] = '{8'h80, 8'h00, 8'h40};
        logic [13:0] e [3];
        e = '{ev(0, 0, 0, 0, 0), ev(1, 0, 0, 0, 1), ev(1, 0, 0, 1, 1)};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            put_byte(b[i]);
            n_cmp++;
            if (obs() !== e[i]) begin
                n_bad++;
                $display("FAIL lower_clamp[%0d]: got %h, required %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [7:0]  b [4] = '{8'h05, 8'h81, 8'h82, 8'h03};
        logic [13:0] e [4];
        e = '{ev(0, 0, 1, 0, 0), ev(0, 0, 0, 0, 0), ev(0, 0, 1, 0, 0), ev(1, 259, 0, 0, 1)};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            put_byte(b[i]);
            n_cmp++;
            if (obs() !== e[i]) begin
                n_bad++;
                $display("FAIL protocol_err[%0d]: got %h, required %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        put_byte(8'h83);
        put_byte(8'h05);
        n_cmp++;
        if (obs() !== ev(1, 389, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL bp_first: got %h, required %h", obs(), ev(1, 389, 0, 0, 1));
        end
        @(negedge m_clock);
        in_data = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 10'd389}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b data=%0d, required rdy=0 vld=1 data=389",
                         i, in_ready, out_valid, out_data);
            end
            @(posedge m_clock);
        end
        @(negedge m_clock);
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 10'd389}) begin
            n_bad++;
            $display("FAIL bp_release: got rdy=%b vld=%b data=%0d, required rdy=1 vld=1 data=389",
                     in_ready, out_valid, out_data);
        end
        @(posedge m_clock);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (obs() !== ev(1, 390, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL bp_next: got %h, required %h", obs(), ev(1, 390, 0, 0, 1));
        end
        @(posedge m_clock);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        put_byte(8'h83);
        @(negedge m_clock);
        p_reset = 1'b1;
        #1;
        n_cmp++;
        if ({obs(), in_ready} !== {14'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h rdy=%b, required 0000 rdy=1", obs(), in_ready);
        end
        @(negedge m_clock);
        p_reset = 1'b0;
        put_byte(8'h05);
        n_cmp++;
        if (obs() !== ev(0, 0, 1, 0, 0)) begin
            n_bad++;
            $display("FAIL reset_mid_delta: got %h, required %h", obs(), ev(0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_random();
        logic [9:0] q[$];
        logic [7:0] b;
        bit         took;
        bit         exp_ov;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge m_clock);
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 6) == 0)
                in_data = 8'h80 | 8'($urandom_range(0, 127));
            else
                in_data = 8'($urandom_range(0, 127));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ov = (q.size() != 0);
            n_cmp++;
            if ({out_valid, in_ready, synced} !== {exp_ov, ~exp_ov | out_ready, m_sync}) begin
                n_bad++;
                $display("FAIL rand_flags[%0d]: got vld=%b rdy=%b sync=%b, required vld=%b rdy=%b sync=%b",
                         i, out_valid, in_ready, synced, exp_ov, ~exp_ov | out_ready, m_sync);
            end
            if (exp_ov) begin
                n_cmp++;
                if (out_data !== q[0]) begin
                    n_bad++;
                    $display("FAIL rand_data[%0d]: got %0d, required %0d", i, out_data, q[0]);
                end
                if (out_ready) void'(q.pop_front());
            end
            took = in_valid && (~exp_ov || out_ready);
            b = in_data;
            @(posedge m_clock);
            #1;
            if (took) model_step(b);
            else begin m_emit = 0; m_err = 0; m_sat = 0; end
            if (m_emit) q.push_back(10'(m_acc));
            n_cmp++;
            if ({err, sat} !== {m_err, m_sat}) begin
                n_bad++;
                $display("FAIL rand_pulses[%0d]: got err=%b sat=%b, required err=%b sat=%b",
                         i, err, sat, m_err, m_sat);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_keyframe();
        test_upper_clamp();
        test_lower_clamp();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
